// File: rtl/seq_fixed_divider.sv
// seq_fixed_divider
//   Iterative fixed-point divider: quotient = (A << FRAC_BITS) / B, computed by
//   radix-2 restoring long division, one quotient bit per clock.
//   Signed or unsigned operation is selected per operation. The block also
//   provides a true remainder, divide-by-zero and overflow flags, and a
//   valid/ready result handshake.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start/in_ready  operand handshake; A, B and signed_mode are sampled with start
//   out_valid/out_ready  result handshake; results are held until accepted
//   quotient        WIDTH+FRAC_BITS bits, binary point at bit FRAC_BITS
//   remainder       WIDTH bits; A*2^FRAC_BITS = quotient*B + remainder
//   dz, ovf         divide-by-zero and signed-overflow flags, valid with out_valid
module seq_fixed_divider #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         in_ready,
    input  logic                         signed_mode,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH+FRAC_BITS-1:0]   quotient,
    output logic [WIDTH-1:0]             remainder,
    output logic                         dz,
    output logic                         ovf
);

    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic             smode;     // latched signed_mode
    logic             qsign;     // result sign sA^sB
    logic             rsign;     // remainder follows the dividend sign
    logic [N-1:0]     dvd;       // dividend bits still to shift in, MSB first
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   prem;      // partial remainder
    logic [N-1:0]     quo;       // quotient magnitude
    logic [CW-1:0]    cnt;

    // Operand magnitudes at acceptance. Negating -2^(WIDTH-1) yields the
    // same bit pattern, which is the correct unsigned magnitude.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    always_comb begin
        a_neg    = signed_mode & A[WIDTH-1];
        b_neg    = signed_mode & B[WIDTH-1];
        a_mag_in = a_neg ? (~A + 1'b1) : A;
        b_mag_in = b_neg ? (~B + 1'b1) : B;
    end

    // One restoring step: shift the next dividend bit in, trial-subtract |B|.
    // The restored remainder is always below |B|, so its low WIDTH bits hold it.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = {prem[WIDTH-1:0], dvd[N-1]};
        diff    = {1'b0, shifted} - {2'b00, b_mag};
        borrow  = diff[WIDTH+1];
    end

    // Sign application and overflow detection for the FIX state. A positive
    // signed result whose magnitude reaches bit N-1 cannot be represented;
    // this happens only for -2^(WIDTH-1) / -1.
    logic [N-1:0]     quo_signed;
    logic [WIDTH-1:0] rem_signed;
    logic             ovf_det;

    always_comb begin
        quo_signed = qsign ? (~quo + 1'b1) : quo;
        rem_signed = rsign ? (~prem[WIDTH-1:0] + 1'b1) : prem[WIDTH-1:0];
        ovf_det    = smode & ~qsign & quo[N-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (B == '0) ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smode     <= 1'b0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dvd       <= '0;
            b_mag     <= '0;
            prem      <= '0;
            quo       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        smode <= signed_mode;
                        qsign <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rsign <= a_neg;
                        dvd   <= N'(a_mag_in) << FRAC_BITS;
                        b_mag <= b_mag_in;
                        prem  <= '0;
                        quo   <= '0;
                        cnt   <= CW'(N - 1);
                        ovf   <= 1'b0;
                        if (B == '0) begin
                            dz        <= 1'b1;
                            quotient  <= '1;
                            remainder <= A;
                        end else begin
                            dz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    prem <= borrow ? shifted : diff[WIDTH:0];
                    quo  <= {quo[N-2:0], ~borrow};
                    dvd  <= dvd << 1;
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    if (ovf_det) begin
                        ovf       <= 1'b1;
                        quotient  <= {1'b0, {(N-1){1'b1}}};
                        remainder <= '0;
                    end else begin
                        quotient  <= quo_signed;
                        remainder <= rem_signed;
                    end
                end
                default: ;  // DONE holds results until accepted
            endcase
        end
    end

endmodule
